// File: rtl/stack_pointer_unit.sv
// Two-stage stack pointer: clk-domain up/down/load counter,
// iclk-strobed holding register driving the shared address bus.
module stack_pointer_unit #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             iclk,
  input  logic             outn,
  input  logic             loadn,
  input  logic             cupn,
  input  logic             cdownn,
  inout  wire  [WIDTH-1:0] abus
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] r_cnt;
  logic [WIDTH-1:0] r_outr;
  logic [WIDTH-1:0] w_cnt_nxt;
  logic             w_load;
  logic             w_up;
  logic             w_dn;

  // Load wins; up/down only when exactly one is asserted.
  assign w_load = !loadn;
  assign w_up   = loadn && !cupn && cdownn;
  assign w_dn   = loadn && cupn && !cdownn;

  always_comb begin
    w_cnt_nxt = r_cnt;
    unique case (1'b1)
      w_load:  w_cnt_nxt = abus;
      w_up:    w_cnt_nxt = r_cnt + ONE;
      w_dn:    w_cnt_nxt = r_cnt - ONE;
      default: w_cnt_nxt = r_cnt;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_cnt <= '0;
    else       r_cnt <= w_cnt_nxt;
  end

  // Holding register is deliberately unreset.
  always_ff @(posedge iclk) begin
    r_outr <= r_cnt;
  end

  assign abus = outn ? {WIDTH{1'bz}} : r_outr;

endmodule

// File: tb/tb_stack_pointer_unit.sv
// Bench for stack_pointer_unit: vector table, corner sequences
// and randomized traffic against an arithmetic model.
module tb_stack_pointer_unit;

  logic        clk;
  logic        reset;
  logic        iclk;
  logic        outn;
  logic        loadn;
  logic        cupn;
  logic        cdownn;
  logic        drv_en;
  logic [15:0] drv;
  wire  [15:0] abus;

  assign abus = drv_en ? drv : 16'hzzzz;

  stack_pointer_unit #(.WIDTH(16)) dut (
    .clk    (clk),
    .reset  (reset),
    .iclk   (iclk),
    .outn   (outn),
    .loadn  (loadn),
    .cupn   (cupn),
    .cdownn (cdownn),
    .abus   (abus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int model;
  logic [15:0] vis;

  typedef struct {
    bit          ldn;
    bit          upn;
    bit          dnn;
    logic [15:0] data;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string nm, input logic [15:0] act,
                     input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic clk_pulse();
    #2 clk = 1'b1;
    #3 clk = 1'b0;
    #2;
  endtask

  task automatic iclk_pulse();
    #2 iclk = 1'b1;
    #3 iclk = 1'b0;
    #2;
  endtask

  // One clk edge with the given controls, then an iclk strobe.
  // abus must hold its old value until the strobe.
  task automatic step(input bit ldn, input bit upn, input bit dnn,
                      input logic [15:0] d, input logic [15:0] exp,
                      input string nm);
    loadn  = ldn;
    cupn   = upn;
    cdownn = dnn;
    if (!ldn) begin
      outn   = 1'b1;
      drv    = d;
      drv_en = 1'b1;
    end
    clk_pulse();
    loadn  = 1'b1;
    cupn   = 1'b1;
    cdownn = 1'b1;
    drv_en = 1'b0;
    outn   = 1'b0;
    #1;
    chk({nm, "_pre_iclk"}, abus, vis);
    iclk_pulse();
    chk(nm, abus, exp);
    vis = exp;
  endtask

  initial begin
    clk = 0; iclk = 0; reset = 1; outn = 1;
    loadn = 1; cupn = 1; cdownn = 1;
    drv_en = 0; drv = '0;
    vecs[0]  = '{0, 1, 1, 16'h1234, 16'h1234};
    vecs[1]  = '{1, 0, 1, 16'h0000, 16'h1235};
    vecs[2]  = '{1, 1, 0, 16'h0000, 16'h1234};
    vecs[3]  = '{1, 0, 0, 16'h0000, 16'h1234};
    vecs[4]  = '{1, 1, 1, 16'h0000, 16'h1234};
    vecs[5]  = '{0, 0, 1, 16'hABCD, 16'hABCD};
    vecs[6]  = '{0, 1, 0, 16'h0000, 16'h0000};
    vecs[7]  = '{1, 1, 0, 16'h0000, 16'hFFFF};
    vecs[8]  = '{1, 0, 1, 16'h0000, 16'h0000};
    vecs[9]  = '{0, 1, 1, 16'hFFFF, 16'hFFFF};
    vecs[10] = '{1, 0, 1, 16'h0000, 16'h0000};
    vecs[11] = '{0, 0, 0, 16'h8000, 16'h8000};

    // Power-up under reset: strobe exposes zero.
    #5;
    iclk_pulse();
    outn = 0;
    #1;
    chk("reset_state", abus, 16'h0000);
    vis = 16'h0000;
    reset = 0;

    step(1, 0, 1, 16'h0, 16'h0001, "up_first");
    step(1, 1, 0, 16'h0, 16'h0000, "down_first");
    step(0, 1, 1, 16'hBEEF, 16'hBEEF, "load_beef");

    // Released bus: with outn=1 an external zero must read back.
    outn = 1; drv = 16'h0000; drv_en = 1;
    #1;
    chk("bus_release", abus, 16'h0000);
    drv_en = 0; outn = 0;
    #1;
    chk("bus_drive", abus, 16'hBEEF);

    for (int i = 0; i < 12; i++)
      step(vecs[i].ldn, vecs[i].upn, vecs[i].dnn, vecs[i].data,
           vecs[i].exp, $sformatf("vec%0d", i));

    // Wrap upward through 0xFFFF.
    step(0, 1, 1, 16'hFFF0, 16'hFFF0, "load_wrap_up");
    for (int i = 1; i <= 40; i++)
      step(1, 0, 1, 16'h0, 16'((32'hFFF0 + i) % 32'h10000),
           $sformatf("wrap_up%0d", i));

    // Wrap downward through 0x0000.
    step(0, 1, 1, 16'h000F, 16'h000F, "load_wrap_dn");
    for (int i = 1; i <= 40; i++)
      step(1, 1, 0, 16'h0, 16'((32'h1000F - i) % 32'h10000),
           $sformatf("wrap_dn%0d", i));

    // Async reset mid-count: abus unchanged until strobe.
    reset = 1;
    #1;
    chk("async_rst_hidden", abus, vis);
    iclk_pulse();
    chk("async_rst_seen", abus, 16'h0000);
    vis = 16'h0000;
    reset = 0;
    step(1, 0, 1, 16'h0, 16'h0001, "resume_up");
    step(1, 0, 1, 16'h0, 16'h0002, "resume_up2");

    // Reset held across a counting clk edge.
    reset = 1; cupn = 0;
    clk_pulse();
    cupn = 1; reset = 0;
    iclk_pulse();
    chk("rst_over_count", abus, 16'h0000);
    vis = 16'h0000;

    // Randomized traffic against an arithmetic model.
    model = 0;
    for (int i = 0; i < 400; i++) begin
      bit ldn, upn, dnn;
      logic [15:0] d;
      ldn = ($urandom_range(0, 7) != 0);
      upn = $urandom_range(0, 1);
      dnn = $urandom_range(0, 1);
      d   = 16'($urandom);
      if ($urandom_range(0, 49) == 0) begin
        reset = 1;
        #1 reset = 0;
        model = 0;
        iclk_pulse();
        chk($sformatf("rnd_rst%0d", i), abus, 16'h0000);
        vis = 16'h0000;
      end
      if (!ldn)
        model = d;
      else if (!upn && dnn)
        model = (model + 1) % 65536;
      else if (upn && !dnn)
        model = (model + 65535) % 65536;
      step(ldn, upn, dnn, d, 16'(model), $sformatf("rnd%0d", i));
      if ($urandom_range(0, 9) == 0) begin
        outn = 1; drv = ~vis; drv_en = 1;
        #1;
        chk($sformatf("rnd_release%0d", i), abus, ~vis);
        drv_en = 0; outn = 0;
        #1;
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/stack_pointer_unit.md
Name: stack_pointer_unit

Overview:
- 16-bit CPU stack pointer with a two-stage register.
- Stage 1 is a counter updated on the rising edge of clk: load, increment, decrement or hold.
- Stage 2 is an output holding register that copies stage 1 on the rising edge of iclk, the inverted-phase strobe.
- Stage 2 drives the shared address bus through a tri-state buffer when enabled.

Parameters:
WIDTH, 16, counter/bus width in bits; all arithmetic is modulo 2^WIDTH.

Ports:
clk  input  1  system clock; stage-1 counter updates on its rising edge
reset  input  1  asynchronous, active-high reset of the stage-1 counter
iclk  input  1  inverted-phase strobe; stage-2 register loads from stage 1 on its rising edge
outn  input  1  active-low output enable; 0 drives abus with stage 2, 1 releases abus to Z
loadn  input  1  active-low parallel load of stage 1 from abus
cupn  input  1  active-low count up
cdownn  input  1  active-low count down
abus  inout  WIDTH  address bus: read for parallel load, driven with stage-2 value when outn=0

Behaviour:
- Clocking: one clock domain (clk); reset is asynchronous and active-high.
  - iclk is the inverted-phase companion strobe that only clocks the stage-2 holding register.

Stage-1 counter (cnt), updated on the rising edge of clk:
- reset=1: cnt forced to 0 immediately and asynchronously; overrides all other controls while high.
- Otherwise, priority order:
  - loadn=0: cnt <= abus.
  - else cupn=0 and cdownn=1: cnt <= cnt+1.
  - else cdownn=0 and cupn=1: cnt <= cnt-1.
  - else, including cupn=cdownn=0: hold.
- Wrap-around: 0xFFFF+1 = 0x0000; 0x0000-1 = 0xFFFF. No carry/borrow output.

Stage-2 output register (outr):
- On the rising edge of iclk: outr <= cnt.
- outr has no reset. After power-up it is X until the first iclk edge. A reset becomes visible on abus only after the next iclk edge.
- One clk edge changes cnt but not abus; the following iclk edge makes the new value visible.

Bus driver:
- abus = outr when outn=0, else high-Z. Driving is purely combinational on outn, with no clock.
- When loadn=0 the external source drives abus. Software/microcode must keep outn=1 during the load edge.
  - The block does not arbitrate bus contention.

Other requirements:
- Control inputs are level-sensitive and sampled at the clk rising edge. They may change between edges without effect.
- A reset asserted mid-count clears cnt at once; counting resumes from 0 on the first clk edge after reset is deasserted.

Test Plan:
- Power-up, all controls inactive: abus=Z. Set outn=0: abus=X. Assert reset: abus stays X. Pulse iclk: abus=0x0000.
- Deassert reset, cupn=0, pulse clk: abus=0x0000. Pulse iclk: abus=0x0001. Then cupn=1, cdownn=0, pulse clk: abus=0x0001. Pulse iclk: abus=0x0000.
- outn=1, external driver puts 0xBEEF on abus, loadn=0, pulse clk. Release driver, outn=0: abus=0x0000. Pulse iclk: abus=0xBEEF.
- Reset, iclk pulse, cupn=0, then 65536 (clk, iclk) pairs: abus equals the iteration index before each pair. It ends at 0x0000 after wrap.
- From 0x0000, cdownn=0, then 65537 pairs: abus equals (i & 0xFFFF) for i from 0x10000 down to 0. It ends at 0xFFFF.
- Priority and simultaneous events:
  - loadn=0 with cupn=0 loads abus.
  - cupn=cdownn=0 holds the value.
  - reset asserted with cupn=0 during a clk edge gives cnt=0, visible after the next iclk.
